decode_pipe_stage: RTL and testbench
====================================

Name: decode_pipe_stage

Overview:
Parametrised instruction-decode pipeline stage for the MIPS core. It splits the instruction, reads the two-read/one-write register file with write-back bypass, and extends the immediate. It detects load-use hazards and latches the result into an ID/EX pipeline register with valid/ready handshake, stall and flush. It sits between the fetch stage and the execute stage; the write-back stage drives its write port.

Parameters:
DWIDTH, 32, register/data width in bits (>= 16)
AWIDTH, 5, register address width; file holds 2**AWIDTH entries
SIGN_EXT, 1, 1 = immediate sign-extended to DWIDTH for all opcodes except ANDI/ORI/XORI (zero-extended); 0 = always zero-extended
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports; 0 = no bypass

Ports:
dp_clk  in  1  clock, rising edge
dp_rst  in  1  asynchronous, active-low reset
dp_i_valid  in  1  fetch presents a valid instruction
dp_o_ready  out  1  stage accepts instruction this cycle (comb.)
dp_i_instr  in  32  instruction word
dp_i_flush  in  1  kill the instruction being latched (branch taken)
dp_i_ex_memread  in  1  instruction in EX is a load
dp_i_ex_rt  in  AWIDTH  destination of the load in EX
dp_i_wb_en  in  1  write-back enable
dp_i_wb_addr  in  AWIDTH  write-back register
dp_i_wb_data  in  DWIDTH  write-back data
dp_i_ready  in  1  execute stage accepts output
dp_o_valid  out  1  ID/EX register holds a valid instruction
dp_o_opcode  out  6  instr[31:26]
dp_o_funct  out  6  instr[5:0]
dp_o_addr_rs / dp_o_addr_rt  out  AWIDTH  source register addresses
dp_o_addr_dst  out  AWIDTH  destination: rd if opcode==0 (R-type), else rt
dp_o_data_rs / dp_o_data_rt  out  DWIDTH  operand values
dp_o_imm  out  DWIDTH  extended immediate
dp_o_stall  out  1  load-use hazard detected (comb.)

Behaviour:
- Fields: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], each taken as the low AWIDTH bits (zero-padded if AWIDTH > 5); imm = instr[15:0].
- Reset (dp_rst = 0, asynchronous): every ID/EX output is 0, dp_o_valid = 0, and every register-file entry is 0.
- Hazard: hazard = dp_i_valid & dp_i_ex_memread & (dp_i_ex_rt != 0) & (dp_i_ex_rt == rs | dp_i_ex_rt == rt). dp_o_stall = hazard.
- dp_o_ready = ~hazard & (dp_i_ready | ~dp_o_valid).
- Update at posedge, highest priority first:
  1. Hold: if dp_o_valid & ~dp_i_ready, all outputs are held and dp_i_flush is ignored. The execute stage owns the held instruction.
  2. Flush: dp_o_valid <= 0. Data outputs are don't-care; the implementation holds them.
  3. Bubble: on a hazard, dp_o_valid <= 0. Upstream holds dp_i_instr because dp_o_ready = 0.
  4. Load: dp_o_valid <= dp_i_valid and all fields are registered.
- Latency: one cycle from accepted instruction to dp_o_valid. A load-use pair inserts exactly one bubble.
- Register file:
  - Write at posedge when dp_i_wb_en & (dp_i_wb_addr != 0); entry 0 always reads 0.
  - Reads are combinational.
  - With BYPASS = 1: if dp_i_wb_en & wb_addr == read addr & wb_addr != 0, the read returns dp_i_wb_data in the same cycle.
  - With BYPASS = 0: the read returns the old value.
- Write-back is independent of hold, stall and flush; writes occur in every cycle when enabled.
- Immediate extension: 16 → DWIDTH per the SIGN_EXT rule. ANDI = 0x0C, ORI = 0x0D, XORI = 0x0E.
- Reset deasserted mid-stream: the first accepted instruction loads normally; no state survives reset.

Decomposition:
- Shared header: DWIDTH/AWIDTH defaults, OPCODE_WIDTH = 6, FUNCT_WIDTH = 6, IMM_WIDTH = 16, and opcode constants (R-type 0x00, LW 0x23, ANDI, ORI, XORI).
- One sub-module, regfile_bypass: 2R1W register file, parametrised by DWIDTH/AWIDTH/BYPASS, async active-low reset, r0 hardwired to zero.
- Hazard logic, extension and the ID/EX register stay in decode_pipe_stage.

Test Plan:
- Reset then write: after reset all outputs are 0. WB writes r8 = 0x0000_1234. Then ADD r10,r8,r9 (0x0109_5020) → next cycle valid = 1, data_rs = 0x1234, data_rt = 0, addr_dst = 10, funct = 0x20.
- Bypass: wb_en = 1, wb_addr = 8, wb_data = 0xDEAD_BEEF in the same cycle as instr reading r8 → data_rs = 0xDEADBEEF with BYPASS = 1; old value with BYPASS = 0. A write to r0 is ignored, so r0 reads 0.
- Immediate: ADDI r1,r0,-4 (0x2001_FFFC) → imm = 0xFFFF_FFFC. ORI r1,r0,0xFFFC → imm = 0x0000_FFFC. With SIGN_EXT = 0, both give 0x0000_FFFC.
- Load-use: ex_memread = 1, ex_rt = 8, instr uses r8 → dp_o_stall = 1, dp_o_ready = 0, next valid = 0. Next cycle ex_memread = 0 → instruction loads, valid = 1. With ex_rt = 0 there is no stall.
- Backpressure: valid output, dp_i_ready = 0 for 3 cycles with a new instr and flush asserted → outputs are unchanged and dp_o_ready = 0. On release, the new instr loads.
- Flush: dp_i_flush = 1 with a valid instr and dp_i_ready = 1 → next cycle valid = 0. Async reset asserted mid-stream → valid = 0 and regs = 0 immediately, without a clock edge.

Source files
------------

// File: rtl/decode_pipe_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage_pkg
//
// Shared definitions for the instruction-decode stage of the MIPS core:
// default data/register widths, instruction field geometry, the opcodes the
// decode stage treats specially, and the encoding of the ID/EX register
// update decision.
//
// Contents:
//   DWIDTH_DEFAULT / AWIDTH_DEFAULT  default datapath and register-address width
//   INSTR_WIDTH                      fetch word width (fixed 32-bit MIPS)
//   OPCODE_WIDTH / FUNCT_WIDTH       opcode and funct field widths
//   IMM_WIDTH                        raw immediate width
//   *_LSB / REG_FIELD_WIDTH          instruction field positions
//   opcode_e                         opcodes of interest to decode
//   idex_action_e                    what the ID/EX register does this cycle
//   is_logical_imm()                 true for ANDI/ORI/XORI (zero-extended imm)
// ---------------------------------------------------------------------------
package decode_pipe_stage_pkg;

  localparam int DWIDTH_DEFAULT  = 32;
  localparam int AWIDTH_DEFAULT  = 5;

  localparam int INSTR_WIDTH     = 32;
  localparam int OPCODE_WIDTH    = 6;
  localparam int FUNCT_WIDTH     = 6;
  localparam int IMM_WIDTH       = 16;

  // Instruction field positions (MIPS I-type / R-type layout)
  localparam int OPCODE_LSB      = 26;
  localparam int RS_LSB          = 21;
  localparam int RT_LSB          = 16;
  localparam int RD_LSB          = 11;
  localparam int FUNCT_LSB       = 0;
  localparam int IMM_LSB         = 0;
  localparam int REG_FIELD_WIDTH = 5;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_RTYPE = 6'h00,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LW    = 6'h23
  } opcode_e;

  // Update decision for the ID/EX register, listed highest priority first
  typedef enum logic [1:0] {
    IDEX_HOLD   = 2'd0,
    IDEX_FLUSH  = 2'd1,
    IDEX_BUBBLE = 2'd2,
    IDEX_LOAD   = 2'd3
  } idex_action_e;

  // Logical immediates are bit masks, so they are never sign-extended
  function automatic logic is_logical_imm(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/decode_pipe_stage_regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass
//
// Two-read / one-write register file with optional same-cycle write-back
// forwarding. Register 0 is hardwired to zero: writes to it are dropped and
// reads of it always return zero, even while it is being "written".
//
// Parameters:
//   DWIDTH  data width
//   AWIDTH  address width, file holds 2**AWIDTH entries
//   BYPASS  1 = a read of the address being written returns the write data
//           in the same cycle; 0 = the read returns the stored (old) value
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset, clears every entry
//   wr_en      write enable
//   wr_addr    write address
//   wr_data    write data
//   rd_addr_a  read port A address    rd_data_a  read port A data (comb.)
//   rd_addr_b  read port B address    rd_data_b  read port B data (comb.)
// ---------------------------------------------------------------------------
module regfile_bypass
  import decode_pipe_stage_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEFAULT,
  parameter int AWIDTH = AWIDTH_DEFAULT,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr_a,
  output logic [DWIDTH-1:0] rd_data_a,
  input  logic [AWIDTH-1:0] rd_addr_b,
  output logic [DWIDTH-1:0] rd_data_b
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic              wr_live;

  // A write only takes effect for non-zero addresses; the same qualifier
  // gates forwarding so r0 can never leak write data.
  assign wr_live = wr_en && (wr_addr != '0);

  // Storage array, cleared as a whole by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port A: r0 is forced to zero, then optional write-back forwarding
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
  end

  // Read port B: identical behaviour to port A
  always_comb begin
    rd_data_b = mem[rd_addr_b];
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage
//
// Instruction-decode stage of the MIPS pipeline. Splits the fetched
// instruction into its fields, reads both source operands from the register
// file (with write-back forwarding), extends the immediate, detects load-use
// hazards and registers everything into the ID/EX pipeline register using a
// valid/ready handshake with stall and flush.
//
// Parameters:
//   DWIDTH    data width (>= 16)
//   AWIDTH    register address width
//   SIGN_EXT  1 = sign-extend immediates except ANDI/ORI/XORI; 0 = zero-extend
//   BYPASS    1 = forward same-cycle write-back data to the read ports
//
// Ports:
//   dp_clk            clock, rising edge
//   dp_rst            asynchronous active-low reset
//   dp_i_valid        fetch presents a valid instruction
//   dp_o_ready        stage accepts the instruction this cycle (comb.)
//   dp_i_instr        instruction word
//   dp_i_flush        kill the instruction being latched
//   dp_i_ex_memread   instruction in EX is a load
//   dp_i_ex_rt        destination register of the load in EX
//   dp_i_wb_en        write-back enable
//   dp_i_wb_addr      write-back register
//   dp_i_wb_data      write-back data
//   dp_i_ready        execute stage accepts the ID/EX contents
//   dp_o_valid        ID/EX register holds a valid instruction
//   dp_o_opcode       instr[31:26]
//   dp_o_funct        instr[5:0]
//   dp_o_addr_rs/rt   source register addresses
//   dp_o_addr_dst     rd for R-type, rt otherwise
//   dp_o_data_rs/rt   source operand values
//   dp_o_imm          extended immediate
//   dp_o_stall        load-use hazard detected (comb.)
// ---------------------------------------------------------------------------
module decode_pipe_stage
  import decode_pipe_stage_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEFAULT,
  parameter int AWIDTH   = AWIDTH_DEFAULT,
  parameter int SIGN_EXT = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    dp_clk,
  input  logic                    dp_rst,
  input  logic                    dp_i_valid,
  output logic                    dp_o_ready,
  input  logic [INSTR_WIDTH-1:0]  dp_i_instr,
  input  logic                    dp_i_flush,
  input  logic                    dp_i_ex_memread,
  input  logic [AWIDTH-1:0]       dp_i_ex_rt,
  input  logic                    dp_i_wb_en,
  input  logic [AWIDTH-1:0]       dp_i_wb_addr,
  input  logic [DWIDTH-1:0]       dp_i_wb_data,
  input  logic                    dp_i_ready,
  output logic                    dp_o_valid,
  output logic [OPCODE_WIDTH-1:0] dp_o_opcode,
  output logic [FUNCT_WIDTH-1:0]  dp_o_funct,
  output logic [AWIDTH-1:0]       dp_o_addr_rs,
  output logic [AWIDTH-1:0]       dp_o_addr_rt,
  output logic [AWIDTH-1:0]       dp_o_addr_dst,
  output logic [DWIDTH-1:0]       dp_o_data_rs,
  output logic [DWIDTH-1:0]       dp_o_data_rt,
  output logic [DWIDTH-1:0]       dp_o_imm,
  output logic                    dp_o_stall
);

  // Decoded fields of the incoming instruction
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [FUNCT_WIDTH-1:0]  funct;
  logic [IMM_WIDTH-1:0]    imm_raw;
  logic [AWIDTH-1:0]       rs;
  logic [AWIDTH-1:0]       rt;
  logic [AWIDTH-1:0]       rd;
  logic [AWIDTH-1:0]       dst;
  logic [DWIDTH-1:0]       imm_ext;
  logic [DWIDTH-1:0]       rs_data;
  logic [DWIDTH-1:0]       rt_data;
  logic                    hazard;
  logic                    hold;
  idex_action_e            action;

  assign opcode  = dp_i_instr[OPCODE_LSB +: OPCODE_WIDTH];
  assign funct   = dp_i_instr[FUNCT_LSB  +: FUNCT_WIDTH];
  assign imm_raw = dp_i_instr[IMM_LSB    +: IMM_WIDTH];

  // The size cast zero-pads when AWIDTH > 5 and keeps the low bits when
  // AWIDTH < 5, so one expression covers every address width.
  assign rs = AWIDTH'(dp_i_instr[RS_LSB +: REG_FIELD_WIDTH]);
  assign rt = AWIDTH'(dp_i_instr[RT_LSB +: REG_FIELD_WIDTH]);
  assign rd = AWIDTH'(dp_i_instr[RD_LSB +: REG_FIELD_WIDTH]);

  // R-type results go to rd; everything else (immediates, loads) writes rt
  assign dst = (opcode == OP_RTYPE) ? rd : rt;

  // Immediate extension: logical immediates are masks and stay unsigned
  always_comb begin
    imm_ext = DWIDTH'(imm_raw);
    if ((SIGN_EXT != 0) && !is_logical_imm(opcode)) begin
      imm_ext = DWIDTH'($signed(imm_raw));
    end
  end

  // Register file; the write-back port runs regardless of stall/hold/flush
  regfile_bypass #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk       (dp_clk),
    .rst_n     (dp_rst),
    .wr_en     (dp_i_wb_en),
    .wr_addr   (dp_i_wb_addr),
    .wr_data   (dp_i_wb_data),
    .rd_addr_a (rs),
    .rd_data_a (rs_data),
    .rd_addr_b (rt),
    .rd_data_b (rt_data)
  );

  // Load-use hazard: the load in EX has not produced its data yet, so an
  // instruction reading that register must wait one cycle. r0 never hazards.
  assign hazard = dp_i_valid && dp_i_ex_memread && (dp_i_ex_rt != '0) &&
                  ((dp_i_ex_rt == rs) || (dp_i_ex_rt == rt));

  assign dp_o_stall = hazard;

  // Execute still owns the held instruction while it has not accepted it
  assign hold = dp_o_valid && !dp_i_ready;

  assign dp_o_ready = !hazard && (dp_i_ready || !dp_o_valid);

  // ID/EX update decision; hold wins over flush so a branch resolved in EX
  // cannot kill the instruction execute has not yet consumed.
  always_comb begin
    action = IDEX_LOAD;
    if (hold) begin
      action = IDEX_HOLD;
    end else if (dp_i_flush) begin
      action = IDEX_FLUSH;
    end else if (hazard) begin
      action = IDEX_BUBBLE;
    end
  end

  // ID/EX pipeline register. Flush and bubble only clear valid; the data
  // fields keep their last value since nobody looks at them while invalid.
  always_ff @(posedge dp_clk or negedge dp_rst) begin
    if (!dp_rst) begin
      dp_o_valid    <= 1'b0;
      dp_o_opcode   <= '0;
      dp_o_funct    <= '0;
      dp_o_addr_rs  <= '0;
      dp_o_addr_rt  <= '0;
      dp_o_addr_dst <= '0;
      dp_o_data_rs  <= '0;
      dp_o_data_rt  <= '0;
      dp_o_imm      <= '0;
    end else begin
      case (action)
        IDEX_HOLD: begin
        end
        IDEX_FLUSH, IDEX_BUBBLE: begin
          dp_o_valid <= 1'b0;
        end
        IDEX_LOAD: begin
          dp_o_valid    <= dp_i_valid;
          dp_o_opcode   <= opcode;
          dp_o_funct    <= funct;
          dp_o_addr_rs  <= rs;
          dp_o_addr_rt  <= rt;
          dp_o_addr_dst <= dst;
          dp_o_data_rs  <= rs_data;
          dp_o_data_rt  <= rt_data;
          dp_o_imm      <= imm_ext;
        end
        default: begin
          dp_o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_stage
//
// Drives two decode stages in parallel from the same stimulus: dut_a uses
// SIGN_EXT=1/BYPASS=1, dut_b uses SIGN_EXT=0/BYPASS=0. A behavioural model
// tracks the architectural register file and the ID/EX contents from the
// stage's rules, and every scenario task compares DUT outputs against either
// hand-derived constants or that model.
// ---------------------------------------------------------------------------
module tb_decode_pipe_stage;

  localparam int PW = 1 + 6 + 6 + 5 + 5 + 5 + 32 * 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] instr;
  logic        flush;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        i_ready;

  logic        a_ready, a_valid, a_stall;
  logic [5:0]  a_opcode, a_funct;
  logic [4:0]  a_rs, a_rt, a_dst;
  logic [31:0] a_drs, a_drt, a_imm;
  logic        b_ready, b_valid, b_stall;
  logic [5:0]  b_opcode, b_funct;
  logic [4:0]  b_rs, b_rt, b_dst;
  logic [31:0] b_drs, b_drt, b_imm;

  logic [PW-1:0] a_obs, b_obs;
  assign a_obs = {a_valid, a_opcode, a_funct, a_rs, a_rt, a_dst, a_drs, a_drt, a_imm};
  assign b_obs = {b_valid, b_opcode, b_funct, b_rs, b_rt, b_dst, b_drs, b_drt, b_imm};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_pipe_stage #(.DWIDTH(32), .AWIDTH(5), .SIGN_EXT(1), .BYPASS(1)) dut_a (
    .dp_clk(clk), .dp_rst(rst_n), .dp_i_valid(i_valid), .dp_o_ready(a_ready),
    .dp_i_instr(instr), .dp_i_flush(flush), .dp_i_ex_memread(ex_memread),
    .dp_i_ex_rt(ex_rt), .dp_i_wb_en(wb_en), .dp_i_wb_addr(wb_addr),
    .dp_i_wb_data(wb_data), .dp_i_ready(i_ready), .dp_o_valid(a_valid),
    .dp_o_opcode(a_opcode), .dp_o_funct(a_funct), .dp_o_addr_rs(a_rs),
    .dp_o_addr_rt(a_rt), .dp_o_addr_dst(a_dst), .dp_o_data_rs(a_drs),
    .dp_o_data_rt(a_drt), .dp_o_imm(a_imm), .dp_o_stall(a_stall)
  );

  decode_pipe_stage #(.DWIDTH(32), .AWIDTH(5), .SIGN_EXT(0), .BYPASS(0)) dut_b (
    .dp_clk(clk), .dp_rst(rst_n), .dp_i_valid(i_valid), .dp_o_ready(b_ready),
    .dp_i_instr(instr), .dp_i_flush(flush), .dp_i_ex_memread(ex_memread),
    .dp_i_ex_rt(ex_rt), .dp_i_wb_en(wb_en), .dp_i_wb_addr(wb_addr),
    .dp_i_wb_data(wb_data), .dp_i_ready(i_ready), .dp_o_valid(b_valid),
    .dp_o_opcode(b_opcode), .dp_o_funct(b_funct), .dp_o_addr_rs(b_rs),
    .dp_o_addr_rt(b_rt), .dp_o_addr_dst(b_dst), .dp_o_data_rs(b_drs),
    .dp_o_data_rt(b_drt), .dp_o_imm(b_imm), .dp_o_stall(b_stall)
  );

  // Behavioural model: architectural registers plus the instruction and
  // operand values latched into ID/EX.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_drs_a, m_drt_a, m_drs_b, m_drt_b;

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_hazard();
    return i_valid && ex_memread && (ex_rt != 5'd0) &&
           (ex_rt == instr[25:21] || ex_rt == instr[20:16]);
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && (i_ready || !m_valid);
  endfunction

  function automatic logic [PW-1:0] exp_pack(input bit side_b);
    logic [5:0]  op;
    logic [4:0]  dst;
    logic [31:0] imm;
    bit          logical;
    op      = m_instr[31:26];
    dst     = (op == 6'h00) ? m_instr[15:11] : m_instr[20:16];
    logical = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
    if (!side_b && !logical) imm = {{16{m_instr[15]}}, m_instr[15:0]};
    else                     imm = {16'h0000, m_instr[15:0]};
    return {m_valid, op, m_instr[5:0], m_instr[25:21], m_instr[20:16], dst,
            side_b ? m_drs_b : m_drs_a, side_b ? m_drt_b : m_drt_a, imm};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_instr <= '0;
      m_drs_a <= '0;
      m_drt_a <= '0;
      m_drs_b <= '0;
      m_drt_b <= '0;
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
    end else begin
      if (m_valid && !i_ready) begin
        m_valid <= m_valid;
      end else if (flush || m_hazard()) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= i_valid;
        m_instr <= instr;
        m_drs_a <= m_read(instr[25:21], 1'b1);
        m_drt_a <= m_read(instr[20:16], 1'b1);
        m_drs_b <= m_read(instr[25:21], 1'b0);
        m_drt_b <= m_read(instr[20:16], 1'b0);
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] <= wb_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus_idle();
    i_valid = 0; instr = 0; flush = 0; ex_memread = 0; ex_rt = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; i_ready = 1;
  endtask

  task automatic test_reset();
    applyStimulus_idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (a_obs !== '0) begin n_errors++; $display("[TB] FAIL reset_a got %h exp 0", a_obs); end
    n_checks++; if (b_obs !== '0) begin n_errors++; $display("[TB] FAIL reset_b got %h exp 0", b_obs); end
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_ready got %b exp 1", a_ready); end
    n_checks++; if (a_stall !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_stall got %b exp 0", a_stall); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_add();
    wb_en = 1; wb_addr = 8; wb_data = 32'h0000_1234;
    tick();
    wb_en = 0; i_valid = 1; instr = 32'h0109_5020;
    tick();
    n_checks++; if (a_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL add_valid got %b exp 1", a_valid); end
    n_checks++; if (a_drs !== 32'h1234) begin n_errors++; $display("[TB] FAIL add_rs got %h exp 1234", a_drs); end
    n_checks++; if (a_drt !== 32'h0) begin n_errors++; $display("[TB] FAIL add_rt got %h exp 0", a_drt); end
    n_checks++; if (a_dst !== 5'd10) begin n_errors++; $display("[TB] FAIL add_dst got %0d exp 10", a_dst); end
    n_checks++; if (a_funct !== 6'h20) begin n_errors++; $display("[TB] FAIL add_funct got %h exp 20", a_funct); end
    n_checks++; if (b_drs !== 32'h1234) begin n_errors++; $display("[TB] FAIL add_rs_b got %h exp 1234", b_drs); end
    i_valid = 0;
  endtask

  task automatic test_bypass();
    i_valid = 1; instr = 32'h0109_5020;
    wb_en = 1; wb_addr = 8; wb_data = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (a_drs !== 32'hDEAD_BEEF) begin n_errors++; $display("[TB] FAIL byp_a got %h exp deadbeef", a_drs); end
    n_checks++; if (b_drs !== 32'h0000_1234) begin n_errors++; $display("[TB] FAIL byp_b got %h exp 1234", b_drs); end
    instr = 32'h0008_5020; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    tick();
    n_checks++; if (a_drs !== 32'h0) begin n_errors++; $display("[TB] FAIL r0_byp got %h exp 0", a_drs); end
    n_checks++; if (b_drt !== 32'hDEAD_BEEF) begin n_errors++; $display("[TB] FAIL wb_stored got %h exp deadbeef", b_drt); end
    wb_en = 0;
    tick();
    n_checks++; if (a_drs !== 32'h0) begin n_errors++; $display("[TB] FAIL r0_write got %h exp 0", a_drs); end
    n_checks++; if (b_drs !== 32'h0) begin n_errors++; $display("[TB] FAIL r0_write_b got %h exp 0", b_drs); end
    i_valid = 0;
  endtask

  task automatic test_immediate();
    logic [31:0] tbl_instr [6];
    logic [31:0] tbl_imm_a [6];
    logic [31:0] tbl_imm_b [6];
    logic [4:0]  tbl_dst   [6];
    tbl_instr = '{32'h2001_FFFC, 32'h3401_FFFC, 32'h3001_FFFC, 32'h3801_FFFC, 32'h8C28_8000, 32'h2001_0123};
    tbl_imm_a = '{32'hFFFF_FFFC, 32'h0000_FFFC, 32'h0000_FFFC, 32'h0000_FFFC, 32'hFFFF_8000, 32'h0000_0123};
    tbl_imm_b = '{32'h0000_FFFC, 32'h0000_FFFC, 32'h0000_FFFC, 32'h0000_FFFC, 32'h0000_8000, 32'h0000_0123};
    tbl_dst   = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd8, 5'd1};
    i_valid = 1;
    for (int k = 0; k < 6; k++) begin
      instr = tbl_instr[k];
      tick();
      n_checks++; if (a_imm !== tbl_imm_a[k]) begin n_errors++; $display("[TB] FAIL imm_a[%0d] got %h exp %h", k, a_imm, tbl_imm_a[k]); end
      n_checks++; if (b_imm !== tbl_imm_b[k]) begin n_errors++; $display("[TB] FAIL imm_b[%0d] got %h exp %h", k, b_imm, tbl_imm_b[k]); end
      n_checks++; if (a_dst !== tbl_dst[k]) begin n_errors++; $display("[TB] FAIL imm_dst[%0d] got %0d exp %0d", k, a_dst, tbl_dst[k]); end
    end
    i_valid = 0;
  endtask

  task automatic test_load_use();
    i_valid = 1; instr = 32'h0109_5020; ex_memread = 1; ex_rt = 8;
    #1;
    n_checks++; if (a_stall !== 1'b1) begin n_errors++; $display("[TB] FAIL lu_stall got %b exp 1", a_stall); end
    n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL lu_ready got %b exp 0", a_ready); end
    tick();
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL lu_bubble got %b exp 0", a_valid); end
    ex_memread = 0;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL lu_release got %b exp 1", a_ready); end
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_rs !== 5'd8) begin n_errors++; $display("[TB] FAIL lu_load got %b/%0d exp 1/8", a_valid, a_rs); end
    ex_memread = 1; ex_rt = 9;
    #1;
    n_checks++; if (b_stall !== 1'b1) begin n_errors++; $display("[TB] FAIL lu_rt got %b exp 1", b_stall); end
    ex_rt = 0; instr = 32'h0000_5020;
    #1;
    n_checks++; if (a_stall !== 1'b0) begin n_errors++; $display("[TB] FAIL lu_r0 got %b exp 0", a_stall); end
    ex_rt = 8; instr = 32'h0109_5020; i_valid = 0;
    #1;
    n_checks++; if (a_stall !== 1'b0) begin n_errors++; $display("[TB] FAIL lu_novalid got %b exp 0", a_stall); end
    ex_memread = 0; ex_rt = 0;
    tick();
  endtask

  task automatic test_backpressure();
    i_valid = 1; instr = 32'h0109_5020; i_ready = 1;
    tick();
    instr = 32'h2001_FFFC; flush = 1; i_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL bp_ready[%0d] got %b exp 0", k, a_ready); end
      tick();
      n_checks++; if (a_valid !== 1'b1 || a_dst !== 5'd10 || a_opcode !== 6'h00) begin
        n_errors++; $display("[TB] FAIL bp_hold[%0d] got %b/%0d/%h exp 1/10/00", k, a_valid, a_dst, a_opcode); end
      n_checks++; if (b_obs !== exp_pack(1'b1)) begin n_errors++; $display("[TB] FAIL bp_model[%0d] got %h exp %h", k, b_obs, exp_pack(1'b1)); end
    end
    flush = 0; i_ready = 1;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL bp_rel_ready got %b exp 1", a_ready); end
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_opcode !== 6'h08 || a_imm !== 32'hFFFF_FFFC) begin
      n_errors++; $display("[TB] FAIL bp_new got %b/%h/%h exp 1/08/fffffffc", a_valid, a_opcode, a_imm); end
    i_valid = 0;
  endtask

  task automatic test_flush();
    i_valid = 1; instr = 32'h0109_5020; tick();
    flush = 1;
    tick();
    n_checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL flush got %b%b exp 00", a_valid, b_valid); end
    flush = 0; i_valid = 0;
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    ops = '{6'h00, 6'h23, 6'h0C, 6'h0D, 6'h0E, 6'h08, 6'h2B};
    for (int c = 0; c < 400; c++) begin
      i_valid    = ($urandom % 4) != 0;
      instr      = {ops[$urandom % 7], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      flush      = ($urandom % 8) == 0;
      ex_memread = ($urandom % 3) == 0;
      ex_rt      = 5'($urandom_range(0, 7));
      wb_en      = ($urandom % 2) == 0;
      wb_addr    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      i_ready    = ($urandom % 4) != 0;
      #1;
      n_checks++; if (a_stall !== m_hazard() || a_ready !== m_ready() || b_ready !== m_ready()) begin
        n_errors++; $display("[TB] FAIL rnd_hs[%0d] got %b%b%b exp %b%b%b", c, a_stall, a_ready, b_ready, m_hazard(), m_ready(), m_ready()); end
      tick();
      n_checks++; if (a_valid !== m_valid) begin n_errors++; $display("[TB] FAIL rnd_valid[%0d] got %b exp %b", c, a_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if (a_obs !== exp_pack(1'b0)) begin n_errors++; $display("[TB] FAIL rnd_a[%0d] got %h exp %h", c, a_obs, exp_pack(1'b0)); end
        n_checks++; if (b_obs !== exp_pack(1'b1)) begin n_errors++; $display("[TB] FAIL rnd_b[%0d] got %h exp %h", c, b_obs, exp_pack(1'b1)); end
      end
    end
    applyStimulus_idle();
    tick();
  endtask

  task automatic test_async_reset();
    wb_en = 1; wb_addr = 8; wb_data = 32'h0BAD_F00D; tick();
    wb_en = 0; i_valid = 1; instr = 32'h0109_5020; tick();
    n_checks++; if (a_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL ar_pre got %b exp 1", a_valid); end
    #2 rst_n = 0;
    #1;
    n_checks++; if (a_obs !== '0) begin n_errors++; $display("[TB] FAIL ar_clear got %h exp 0", a_obs); end
    @(negedge clk);
    rst_n = 1;
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_drs !== 32'h0 || b_drs !== 32'h0) begin
      n_errors++; $display("[TB] FAIL ar_regs got %b/%h/%h exp 1/0/0", a_valid, a_drs, b_drs); end
    i_valid = 0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_write_add();
    test_bypass();
    test_immediate();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
